// File: rtl/fnd_scan_ctrl_if.sv
// fnd_scan_ctrl_if: bundle of display inputs and scan outputs
// for the 4-digit FND multiplexing controller.
interface fnd_scan_ctrl_if;
    logic       enable;
    logic [3:0] digit3;
    logic [3:0] digit2;
    logic [3:0] digit1;
    logic [3:0] digit0;
    logic [3:0] dp_in;
    logic       blank_lz;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;
    logic [1:0] fnd_sel;
    logic       frame_done;

    modport master (
        output enable, digit3, digit2, digit1, digit0, dp_in, blank_lz,
        input  fnd_com, fnd_data, fnd_sel, frame_done
    );

    modport slave (
        input  enable, digit3, digit2, digit1, digit0, dp_in, blank_lz,
        output fnd_com, fnd_data, fnd_sel, frame_done
    );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: 4-digit 7-segment scan controller with dead time,
// per-frame input snapshot and leading-zero blanking.
module fnd_scan_ctrl #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int SCAN_FREQ = 4_000,
    parameter int DEAD_CYC  = 16
) (
    input  logic             clk,
    input  logic             reset,
    fnd_scan_ctrl_if.slave   bus
);

    localparam int DIV = CLK_FREQ / SCAN_FREQ;
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [TW-1:0] DEAD_LAST = TW'(DEAD_CYC - 1);

    typedef enum logic [1:0] {
        S_OFF,
        S_DEAD,
        S_SHOW
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic [3:0]      dp_q, dp_d;
    logic            fd_q, fd_d;
    logic            load;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // State, tick, index, snapshot and frame pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_OFF;
            tick_q  <= '0;
            idx_q   <= '0;
            dig_q   <= '0;
            dp_q    <= '0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            dig_q   <= dig_d;
            dp_q    <= dp_d;
            fd_q    <= fd_d;
        end
    end

    // Next-state: slot timing, digit stepping, snapshot reload on frame wrap
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        dig_d   = dig_q;
        dp_d    = dp_q;
        fd_d    = 1'b0;
        load    = 1'b0;
        if (!bus.enable) begin
            state_d = S_OFF;
            tick_d  = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                S_OFF: begin
                    state_d = S_DEAD;
                    tick_d  = '0;
                    idx_d   = '0;
                    load    = 1'b1;
                end
                S_DEAD: begin
                    tick_d = tick_q + TW'(1);
                    if (tick_q == DEAD_LAST) begin
                        state_d = S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (tick_q == TICK_LAST) begin
                        state_d = S_DEAD;
                        tick_d  = '0;
                        idx_d   = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            load = 1'b1;
                            fd_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                default: begin
                    state_d = S_OFF;
                    tick_d  = '0;
                    idx_d   = '0;
                end
            endcase
        end
        if (load) begin
            dig_d = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
            dp_d  = bus.dp_in;
        end
    end

    logic [3:0] blank;
    logic [3:0] com;
    logic [7:0] data;

    // Moore output decode; blanking follows the live blank_lz input
    always_comb begin
        blank    = '0;
        blank[3] = bus.blank_lz && (dig_q[3] == 4'h0);
        blank[2] = blank[3] && (dig_q[2] == 4'h0);
        blank[1] = blank[2] && (dig_q[1] == 4'h0);
        com      = 4'hF;
        data     = 8'hFF;
        if (state_q == S_SHOW) begin
            com        = ~(4'b0001 << idx_q);
            data[7]    = ~dp_q[idx_q];
            data[6:0]  = blank[idx_q] ? 7'h7F : seg7(dig_q[idx_q]);
        end
    end

    assign bus.fnd_com    = com;
    assign bus.fnd_data   = data;
    assign bus.fnd_sel    = idx_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: scoreboard bench; a timeline model predicts each
// post-edge display state, a monitor compares it one edge later.
module tb_fnd_scan_ctrl;

    localparam int CF    = 100;
    localparam int SF    = 10;
    localparam int DC    = 2;
    localparam int DIV   = CF / SF;
    localparam int FRAME = 4 * DIV;

    typedef struct packed {
        logic [3:0] com;
        logic [7:0] data;
        logic [1:0] sel;
        logic       fd;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fnd_scan_ctrl_if bus ();

    fnd_scan_ctrl #(
        .CLK_FREQ (CF),
        .SCAN_FREQ(SF),
        .DEAD_CYC (DC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // Model: on/off, position p inside the current frame, snapshot
    bit         m_on = 0;
    int         m_p = 0;
    logic [3:0] m_dig [4];
    logic [3:0] m_dp = '0;
    bit         m_fd = 0;

    function automatic obs_t model_out();
        obs_t o;
        int   slot;
        int   off;
        logic b [4];
        o.fd   = m_fd;
        o.com  = 4'hF;
        o.data = 8'hFF;
        o.sel  = 2'd0;
        if (m_on) begin
            slot  = m_p / DIV;
            off   = m_p % DIV;
            o.sel = slot[1:0];
            b[3] = bus.blank_lz && (m_dig[3] == 4'h0);
            b[2] = b[3] && (m_dig[2] == 4'h0);
            b[1] = b[2] && (m_dig[1] == 4'h0);
            b[0] = 1'b0;
            if (off >= DC) begin
                o.com[slot]    = 1'b0;
                o.data[7]      = ~m_dp[slot];
                o.data[6:0]    = b[slot] ? 7'h7F : SEG[m_dig[slot]];
            end
        end
        return o;
    endfunction

    task automatic snap();
        m_dig[3] = bus.digit3;
        m_dig[2] = bus.digit2;
        m_dig[1] = bus.digit1;
        m_dig[0] = bus.digit0;
        m_dp     = bus.dp_in;
    endtask

    // Apply one clock edge to the model and queue the expected result
    task automatic step();
        m_fd = 0;
        if (reset) begin
            m_on = 0;
            m_p  = 0;
            for (int i = 0; i < 4; i++) m_dig[i] = '0;
            m_dp = '0;
        end else if (!bus.enable) begin
            m_on = 0;
            m_p  = 0;
        end else if (!m_on) begin
            m_on = 1;
            m_p  = 0;
            snap();
        end else begin
            m_p++;
            if (m_p == FRAME) begin
                m_p  = 0;
                m_fd = 1;
                snap();
            end
        end
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0);
        bus.digit3 = d3;
        bus.digit2 = d2;
        bus.digit1 = d1;
        bus.digit0 = d0;
    endtask

    function automatic logic [3:0] rnd_dig();
        if ($urandom_range(0, 2) == 0) return 4'h0;
        return 4'($urandom_range(0, 15));
    endfunction

    // Monitor: compare DUT outputs just after every rising edge
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.fnd_com, bus.fnd_data, bus.fnd_sel, bus.frame_done};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL cyc%0d com/data/sel/fd got %b/%h/%0d/%b want %b/%h/%0d/%b",
                             cyc, a.com, a.data, a.sel, a.fd,
                             e.com, e.data, e.sel, e.fd);
                end
            end
        end
    end

    initial begin
        reset        = 1'b1;
        bus.enable   = 1'b1;
        bus.dp_in    = 4'h0;
        bus.blank_lz = 1'b0;
        set_digits(4'h9, 4'h9, 4'h9, 4'h9);
        run(3);

        reset = 1'b0;
        set_digits(4'h1, 4'h2, 4'h3, 4'h4);
        run(2 * FRAME + 5);

        bus.enable = 1'b0;
        run(2);
        set_digits(4'h0, 4'h0, 4'h5, 4'h0);
        bus.blank_lz = 1'b1;
        bus.enable   = 1'b1;
        run(FRAME + 3);
        bus.blank_lz = 1'b0;
        run(FRAME);

        bus.enable = 1'b0;
        run(1);
        set_digits(4'h3, 4'h2, 4'h0, 4'h1);
        bus.enable = 1'b1;
        run(25);
        bus.digit0 = 4'h7;
        run(FRAME + 20);

        set_digits(4'h8, 4'h8, 4'h8, 4'h8);
        bus.dp_in = 4'b0100;
        run(FRAME + 25);
        bus.enable = 1'b0;
        run(3);
        bus.enable = 1'b1;
        run(15);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(20);

        repeat (3000) begin
            reset = ($urandom_range(0, 199) == 0);
            if (bus.enable) begin
                if ($urandom_range(0, 299) == 0) bus.enable = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                bus.enable = 1'b1;
            end
            if ($urandom_range(0, 19) == 0)
                set_digits(rnd_dig(), rnd_dig(), rnd_dig(), rnd_dig());
            if ($urandom_range(0, 29) == 0)
                bus.dp_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0)
                bus.blank_lz = ~bus.blank_lz;
            step();
        end

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
